// File: rtl/pixel_mem_arbiter_pkg.sv
// Shared definitions for the pixel memory arbiter: bus widths, owner
// encoding for the two requesters, and the return-pipeline stage type.
package pixel_mem_arbiter_pkg;

  localparam int PIX_ADDR_W = 13;
  localparam int PIX_DATA_W = 24;

  // Owner index carried down the return pipeline
  localparam logic OWN_P0 = 1'b0;  // display plane fetch
  localparam logic OWN_P1 = 1'b1;  // overlay / sprite fetch

  typedef struct packed {
    logic valid;
    logic owner;
  } pipe_stage_t;

endpackage

// File: rtl/pixel_mem_arbiter_rr_grant2.sv
// Two-way round-robin grant with an urgent override for requester 0.
// Purely combinational.
//   req0, req1 : access requests
//   urgent0    : requester 0 wins any tie while it is set
//   rr_last    : owner index of the most recent accepted access
//   gnt0, gnt1 : one-hot (or zero) grant
module pixel_mem_arbiter_rr_grant2
  import pixel_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic urgent0,
  input  logic rr_last,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // Tie: urgent wins outright, otherwise whoever did not go last
      if (urgent0 || (rr_last == OWN_P1)) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Shares one synchronous pixel memory read port between the display plane
// fetch (requester 0) and a secondary reader (requester 1). One access is
// accepted per clock; read data comes back in issue order, steered to its
// owner with a one-cycle valid strobe.
//   clk, rst               : clock, asynchronous active-high reset
//   req0/addr0/urgent0     : requester 0 request, address, priority override
//   gnt0, rvalid0, rdata0  : requester 0 grant (comb), return strobe and data
//   req1/addr1             : requester 1 request and address
//   gnt1, rvalid1, rdata1  : requester 1 grant (comb), return strobe and data
//   mem_addr, mem_en       : registered memory address / read enable
//   mem_data               : memory read data, valid MEM_LAT clocks after
//                            mem_addr/mem_en are sampled
// MEM_LAT is expected to lie in 1..4.
module pixel_mem_arbiter
  import pixel_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = PIX_ADDR_W,
  parameter int DATA_W  = PIX_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              urgent0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data
);

  logic                      w_gnt0_raw;
  logic                      w_gnt1_raw;
  logic                      w_accept;
  logic                      w_owner;
  pipe_stage_t               w_stage;
  logic                      w_ret0;
  logic                      w_ret1;

  logic                      r_rr_last;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic                      r_mem_en;
  pipe_stage_t [MEM_LAT:0]   r_pipe;
  logic                      r_rvalid0;
  logic                      r_rvalid1;
  logic [DATA_W-1:0]         r_rdata0;
  logic [DATA_W-1:0]         r_rdata1;

  pixel_mem_arbiter_rr_grant2 u_grant (
    .req0    (req0),
    .req1    (req1),
    .urgent0 (urgent0),
    .rr_last (r_rr_last),
    .gnt0    (w_gnt0_raw),
    .gnt1    (w_gnt1_raw)
  );

  // Grants are suppressed while reset is held so nothing looks accepted
  assign gnt0     = w_gnt0_raw & ~rst;
  assign gnt1     = w_gnt1_raw & ~rst;
  assign w_accept = gnt0 | gnt1;
  assign w_owner  = gnt1 ? OWN_P1 : OWN_P0;

  assign w_stage.valid = w_accept;
  assign w_stage.owner = w_owner;

  // The last stage lines up with mem_data; the output register adds the
  // final clock, giving MEM_LAT+1 clocks from accept to rvalid.
  assign w_ret0 = r_pipe[MEM_LAT].valid && (r_pipe[MEM_LAT].owner == OWN_P0);
  assign w_ret1 = r_pipe[MEM_LAT].valid && (r_pipe[MEM_LAT].owner == OWN_P1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last  <= OWN_P1;  // requester 0 wins the first tie
      r_mem_addr <= '0;
      r_mem_en   <= 1'b0;
      r_pipe     <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_mem_en <= w_accept;
      if (w_accept) begin
        r_mem_addr <= (w_owner == OWN_P1) ? addr1 : addr0;
        r_rr_last  <= w_owner;
      end
      r_pipe    <= {r_pipe[MEM_LAT-1:0], w_stage};
      r_rvalid0 <= w_ret0;
      r_rvalid1 <= w_ret1;
      // Data registers only load for their own owner, so the other side
      // never sees a foreign pixel.
      if (w_ret0) r_rdata0 <= mem_data;
      if (w_ret1) r_rdata1 <= mem_data;
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_en   = r_mem_en;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Bench for pixel_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3)
// share one stimulus stream; a behavioural model predicts grants and the
// in-order return of every accepted read.
module tb_pixel_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, urgent0 = 1'b0;
  logic [12:0] addr0 = '0, addr1 = '0;

  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_en_a;
  logic [23:0] rdata0_a, rdata1_a, mem_data_a;
  logic [12:0] mem_addr_a;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_en_b;
  logic [23:0] rdata0_b, rdata1_b, mem_data_b;
  logic [12:0] mem_addr_b;

  always #5 clk = ~clk;

  pixel_mem_arbiter #(.MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .urgent0(urgent0),
    .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1), .addr1(addr1),
    .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .mem_addr(mem_addr_a), .mem_en(mem_en_a), .mem_data(mem_data_a)
  );

  pixel_mem_arbiter #(.MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .urgent0(urgent0),
    .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1), .addr1(addr1),
    .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_en(mem_en_b), .mem_data(mem_data_b)
  );

  function automatic logic [23:0] rom(input logic [12:0] a);
    logic [23:0] w;
    w = {11'd0, a};
    return w * 24'd3;
  endfunction

  // ROM models: sampled address appears MEM_LAT clocks later
  logic [23:0] mda = '0;
  logic [23:0] mdb [3];
  initial begin
    mdb[0] = '0; mdb[1] = '0; mdb[2] = '0;
  end
  always @(posedge clk) mda <= mem_en_a ? rom(mem_addr_a) : 24'hA5A5A5;
  always @(posedge clk) begin
    mdb[0] <= mem_en_b ? rom(mem_addr_b) : 24'hA5A5A5;
    mdb[1] <= mdb[0];
    mdb[2] <= mdb[1];
  end
  assign mem_data_a = mda;
  assign mem_data_b = mdb[2];

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          n;
    logic        own;
    logic [12:0] addr;
  } acc_t;

  acc_t        q[$];
  int          cyc = 0;
  logic        m_rr_last = 1'b1;
  logic [12:0] m_mem_addr = '0;
  logic        m_mem_en = 1'b0;
  logic        m_rv0_a = 0, m_rv1_a = 0, m_rv0_b = 0, m_rv1_b = 0;
  logic [23:0] m_rd0_a = '0, m_rd1_a = '0, m_rd0_b = '0, m_rd1_b = '0;
  logic        lg0 = 1'b0, lg1 = 1'b0;

  // {gnt1, gnt0} from the arbitration rules
  function automatic logic [1:0] model_gnt();
    if (rst) return 2'b00;
    if (!req0 && !req1) return 2'b00;
    if (req0 && !req1) return 2'b01;
    if (req1 && !req0) return 2'b10;
    if (urgent0) return 2'b01;
    return (m_rr_last == 1'b0) ? 2'b10 : 2'b01;
  endfunction

  initial forever begin
    logic [1:0] g;
    acc_t       e;
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_rr_last = 1'b1; m_mem_addr = '0; m_mem_en = 1'b0;
      m_rv0_a = 0; m_rv1_a = 0; m_rv0_b = 0; m_rv1_b = 0;
      m_rd0_a = '0; m_rd1_a = '0; m_rd0_b = '0; m_rd1_b = '0;
      lg0 = 1'b0; lg1 = 1'b0;
    end else begin
      g = model_gnt();
      cyc++;
      lg0 = g[0];
      lg1 = g[1];
      m_mem_en = (g != 2'b00);
      if (g != 2'b00) begin
        e.n = cyc; e.own = g[1]; e.addr = g[1] ? addr1 : addr0;
        q.push_back(e);
        m_mem_addr = e.addr;
        m_rr_last = g[1];
      end
      m_rv0_a = 0; m_rv1_a = 0; m_rv0_b = 0; m_rv1_b = 0;
      foreach (q[i]) begin
        if (q[i].n + 2 == cyc) begin
          if (q[i].own) begin m_rv1_a = 1; m_rd1_a = rom(q[i].addr); end
          else          begin m_rv0_a = 1; m_rd0_a = rom(q[i].addr); end
        end
        if (q[i].n + 4 == cyc) begin
          if (q[i].own) begin m_rv1_b = 1; m_rd1_b = rom(q[i].addr); end
          else          begin m_rv0_b = 1; m_rd0_b = rom(q[i].addr); end
        end
      end
      while (q.size() > 0 && q[0].n + 4 < cyc) void'(q.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [1:0] g;
    @(negedge clk);
    g = model_gnt();
    chk("gnt0_a", gnt0_a, g[0]);
    chk("gnt1_a", gnt1_a, g[1]);
    chk("gnt0_b", gnt0_b, g[0]);
    chk("gnt1_b", gnt1_b, g[1]);
    chk("mem_en_a", mem_en_a, m_mem_en);
    chk("mem_en_b", mem_en_b, m_mem_en);
    chk("mem_addr_a", mem_addr_a, m_mem_addr);
    chk("mem_addr_b", mem_addr_b, m_mem_addr);
    chk("rvalid0_a", rvalid0_a, m_rv0_a);
    chk("rvalid1_a", rvalid1_a, m_rv1_a);
    chk("rdata0_a", rdata0_a, m_rd0_a);
    chk("rdata1_a", rdata1_a, m_rd1_a);
    chk("rvalid0_b", rvalid0_b, m_rv0_b);
    chk("rvalid1_b", rvalid1_b, m_rv1_b);
    chk("rdata0_b", rdata0_b, m_rd0_b);
    chk("rdata1_b", rdata1_b, m_rd1_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, p0, p1;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 13'h0005; addr1 = 13'h0007;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt0", gnt0_a, 0);
    chk("rst_gnt1", gnt1_a, 0);
    chk("rst_mem_en", mem_en_a, 0);

    // first tie after reset, then single-access returns
    rst = 1'b0;
    #1;
    chk("tie0_gnt0", gnt0_a, 1);
    chk("tie0_gnt1", gnt1_a, 0);
    tick(); req0 = 1'b0; #1;
    chk("solo_gnt1", gnt1_a, 1);
    chk("solo_mem_addr", mem_addr_a, 13'h0005);
    chk("solo_mem_en", mem_en_a, 1);
    tick(); req1 = 1'b0; #1;
    chk("solo_mem_addr1", mem_addr_a, 13'h0007);
    chk("solo_early_rv0", rvalid0_a, 0);
    tick(); #1;
    chk("solo_rv0", rvalid0_a, 1);
    chk("solo_rd0", rdata0_a, 24'h00000F);
    chk("solo_rv1_quiet", rvalid1_a, 0);
    tick(); #1;
    chk("solo_rv1", rvalid1_a, 1);
    chk("solo_rd1", rdata1_a, 24'h000015);
    chk("solo_rd0_hold", rdata0_a, 24'h00000F);
    chk("solo_idle_en", mem_en_a, 0);
    tick(); #1;
    chk("lat3_rv0", rvalid0_b, 1);
    chk("lat3_rd0", rdata0_b, 24'h00000F);

    // fairness: both held, strict alternation
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      req0 = 1'b1; req1 = 1'b1; urgent0 = 1'b0;
      addr0 = 13'(16 + i); addr1 = 13'(32 + i);
      #1;
      chk("fair_gnt0", gnt0_a, (i % 2 == 0) ? 1 : 0);
      n0 += int'(gnt0_a);
    end
    chk("fair_cnt0", n0, 4);

    // urgent override, then requester 1 wins the next tie
    for (int i = 0; i < 5; i++) begin
      tick();
      urgent0 = 1'b1; addr0 = 13'(64 + i); addr1 = 13'(96 + i);
      #1;
      chk("urg_gnt0", gnt0_a, 1);
      chk("urg_gnt1", gnt1_a, 0);
    end
    tick(); urgent0 = 1'b0; #1;
    chk("post_urg_gnt1", gnt1_a, 1);
    tick(); req0 = 1'b0; req1 = 1'b0;
    repeat (6) tick();

    // withdrawal: requester 1 loses once then drops
    req0 = 1'b1; req1 = 1'b1; addr0 = 13'h0100; addr1 = 13'h0200; #1;
    chk("wd_gnt1", gnt1_a, 0);
    tick(); req0 = 1'b0; req1 = 1'b0; #1;
    chk("wd_en", mem_en_a, 1);
    p0 = 0; p1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      p0 += int'(rvalid0_a);
      p1 += int'(rvalid1_a);
      if (i == 0) chk("wd_idle_en", mem_en_a, 0);
    end
    chk("wd_rv0_cnt", p0, 1);
    chk("wd_rv1_cnt", p1, 0);

    // reset with two reads in flight
    tick(); req0 = 1'b1; addr0 = 13'h0123;
    tick(); req0 = 1'b0; req1 = 1'b1; addr1 = 13'h0321;
    tick(); req1 = 1'b0;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; #1;
    chk("mrst_gnt0", gnt0_a, 0);
    chk("mrst_gnt1", gnt1_a, 0);
    chk("mrst_en", mem_en_a, 0);
    chk("mrst_addr", mem_addr_a, 0);
    chk("mrst_rd0", rdata0_a, 0);
    chk("mrst_rd1", rdata1_a, 0);
    chk("mrst_rv_b", {rvalid0_b, rvalid1_b}, 0);
    repeat (2) tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    p0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      p0 += int'(rvalid0_a) + int'(rvalid1_a) + int'(rvalid0_b) + int'(rvalid1_b);
    end
    chk("mrst_no_rv", p0, 0);
    tick(); req0 = 1'b1; req1 = 1'b1; #1;
    chk("mrst_tie_gnt0", gnt0_a, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) rst = 1'b1;
      if (i == 1503) rst = 1'b0;
      if (req0 && !lg0) begin
        if ($urandom_range(0, 9) == 0) req0 = 1'b0;
      end else begin
        req0 = ($urandom_range(0, 99) < 60);
        addr0 = 13'($urandom);
      end
      if (req1 && !lg1) begin
        if ($urandom_range(0, 9) == 0) req1 = 1'b0;
      end else begin
        req1 = ($urandom_range(0, 99) < 60);
        addr1 = 13'($urandom);
      end
      if ($urandom_range(0, 9) == 0) urgent0 = ~urgent0;
    end
    tick(); req0 = 1'b0; req1 = 1'b0; urgent0 = 1'b0;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_mem_arbiter.md
Name: pixel_mem_arbiter

Overview:
- Shares one synchronous pixel memory port (ROM-style, 13-bit address, 24-bit RGB data) between two requesters.
- Requester 0 is the display plane fetch path, which feeds the scan-out FIFO. Requester 1 is a secondary reader, such as an overlay or sprite fetch.
- Arbitration is round-robin, one accepted access per clock.
- Requester 0 has an urgent override, used when the scan-out FIFO runs low.
- Read data returns in order, tagged with a valid strobe to the requester that owns it.

Parameters:
- ADDR_W, 13, pixel memory address width.
- DATA_W, 24, pixel width (8:8:8 RGB).
- MEM_LAT, 1, memory read latency in clocks from mem_addr/mem_en sampled to mem_data valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req0  in  1  requester 0 access request.
- addr0  in  ADDR_W  requester 0 address; valid while req0.
- urgent0  in  1  requester 0 priority override.
- gnt0  out  1  requester 0 request accepted this cycle (combinational).
- rvalid0  out  1  rdata0 valid this cycle.
- rdata0  out  DATA_W  read data to requester 0.
- req1  in  1  requester 1 access request.
- addr1  in  ADDR_W  requester 1 address.
- gnt1  out  1  requester 1 accepted this cycle.
- rvalid1  out  1  rdata1 valid.
- rdata1  out  DATA_W  read data to requester 1.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_en  out  1  registered read enable to memory.
- mem_data  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst=1):
  - mem_addr=0, mem_en=0, rr_last=1 (so requester 0 wins first tie).
  - In-flight pipeline cleared; rvalid0=rvalid1=0.
  - rdata0=rdata1=0; gnt0=gnt1=0 while rst held.
- Grant (combinational, same cycle as request); at most one of gnt0/gnt1 high:
  - Only one requester active -> it is granted.
  - Both active and urgent0=1 -> gnt0.
  - Both active, urgent0=0 -> grant the requester not equal to rr_last.
  - urgent0 with req0=0 has no effect.
- A request is accepted on an edge where reqX & gntX.
  - Requester holds reqX/addrX until gntX is seen.
  - Requester may drop reqX without being granted (no penalty).
- On each accepting edge:
  - mem_addr <= granted addr; mem_en <= 1.
  - rr_last <= granted index.
  - Urgent grants do update rr_last, so requester 1 wins the next tie.
- No accept on an edge -> mem_en <= 0, mem_addr holds its value.
- Return pipeline:
  - Shift register of MEM_LAT+1 stages, each {valid, owner}, loaded at the accepting edge.
  - rvalidX asserted exactly MEM_LAT+1 cycles after the accepting edge (default: 2 cycles), for one cycle.
  - rdataX = mem_data when rvalidX, else holds its last value (registered hold, no combinational glitch to the non-owner).
- Throughput: one accept per cycle sustained; back-to-back accepts from alternating owners return in issue order.
- Starvation bound: with urgent0=0, a continuously requesting requester waits at most 1 cycle.
- Starvation under urgent0: requester 1 may starve while urgent0 and req0 are both held. This is intentional: the scan-out FIFO underflow is worse.
- Reset mid-operation: in-flight reads are discarded and no rvalid is generated for them. Memory data arriving after reset is ignored.
- Simultaneous events:
  - Accept and return can coincide on the same edge for the same owner; both occur.
  - rvalid0 and rvalid1 are never high in the same cycle.

Decomposition:
- Shared package holds:
  - PIX_ADDR_W=13, PIX_DATA_W=24.
  - Owner encoding constants OWN_P0=0, OWN_P1=1.
  - A struct/typedef for a pipeline stage {valid, owner}.
- One sub-module is natural: rr_grant2, the 2-way round-robin/urgent grant logic. It is purely combinational, with inputs req0, req1, urgent0, rr_last and outputs gnt0, gnt1.
- The pipeline and memory registers stay in the top module.

Test Plan:
- Reset behaviour: rst high mid-stream with 2 reads in flight -> all outputs 0 immediately; after release, no rvalid pulse for the discarded reads. First tie after reset goes to requester 0.
- Single requester: req0=1 with addr0=0x0005 held 1 cycle, ROM model returning addr*3 -> gnt0 same cycle, mem_addr=0x0005 next cycle, rvalid0 two cycles after accept with rdata0=0x00000F, rvalid1 stays 0.
- Fairness: req0 and req1 held for 8 cycles, urgent0=0 -> grants alternate 0,1,0,1..., 4 each. rvalids alternate in the same order with matching data.
- Urgent override: both requesting with urgent0=1 for 5 cycles -> 5 consecutive gnt0, gnt1=0. After urgent0 drops -> next grant is requester 1.
- Request withdrawal: req1 held 1 cycle while losing, then dropped -> no access for requester 1, no rvalid1, mem_en low when idle.
- Latency parameter: MEM_LAT=3 with a delayed ROM model, stream of 6 mixed requests -> each rvalid exactly 4 cycles after its accept, correct owner and data, order preserved.
